// File: rtl/lcd_write_arbiter.sv
// Purpose : owns an HD44780 character-LCD write bus; runs the power-up init sequence, then round-robins single-byte writes from two requesters.
// Latency : grant on the IDLE edge that samples req, ack the next cycle; bus busy for T_SETUP+T_PULSE+T_HOLD+exec-wait cycles per byte.
// Backpr. : a request is held off (no ack, not dropped) during init or an active transfer; requester keeps req/rs/data stable until ack.
//
// Ports:
//   clk, reset            system clock, synchronous active-low reset
//   req0/rs0/data0, ack0  requester 0: write request, RS, byte, one-cycle accept pulse
//   req1/rs1/data1, ack1  requester 1: same as requester 0
//   init_done, busy       init sequence complete; engine not in IDLE
//   lcd_data/e/rs/rw      LCD bus (rw tied low, write only)
module lcd_write_arbiter #(
    parameter int T_POWERON = 750000,
    parameter int T_SETUP   = 4,
    parameter int T_PULSE   = 25,
    parameter int T_HOLD    = 4,
    parameter int T_EXEC    = 2000,
    parameter int T_CLEAR   = 82000,
    parameter int CNT_W     = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic       rs0,
    input  logic [7:0] data0,
    output logic       ack0,
    input  logic       req1,
    input  logic       rs1,
    input  logic [7:0] data1,
    output logic       ack1,
    output logic       init_done,
    output logic       busy,
    output logic [7:0] lcd_data,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw
);

    typedef enum logic [2:0] {
        PWR_WAIT,
        LOAD,
        SETUP,
        PULSE,
        HOLD,
        EXEC_WAIT,
        IDLE
    } state_t;

    // Terminal counts: the timer starts at 0 on state entry, so a state
    // lasting T cycles leaves when the timer reaches T-1.
    localparam logic [CNT_W-1:0] LIM_PWR   = CNT_W'(T_POWERON - 1);
    localparam logic [CNT_W-1:0] LIM_SETUP = CNT_W'(T_SETUP - 1);
    localparam logic [CNT_W-1:0] LIM_PULSE = CNT_W'(T_PULSE - 1);
    localparam logic [CNT_W-1:0] LIM_HOLD  = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] LIM_EXEC  = CNT_W'(T_EXEC - 1);
    localparam logic [CNT_W-1:0] LIM_CLEAR = CNT_W'(T_CLEAR - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] timer, tlim;
    logic             timer_done;
    logic [1:0]       idx;
    logic             rr_ptr;
    logic             long_wait;
    logic             grant0, grant1;

    function automatic logic [7:0] init_byte(input logic [1:0] i);
        case (i)
            2'd0:    init_byte = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
            2'd1:    init_byte = 8'h0D;  // display on, cursor off, blink on
            2'd2:    init_byte = 8'h01;  // clear display
            default: init_byte = 8'h80;  // DDRAM address 0
        endcase
    endfunction

    // Clear (0x01) and return-home (0x02/0x03) need the long execution time.
    assign long_wait = !lcd_rs && (lcd_data[7:2] == 6'd0) && (lcd_data[1:0] != 2'd0);

    always_comb begin
        tlim = '0;
        case (state)
            PWR_WAIT:  tlim = LIM_PWR;
            SETUP:     tlim = LIM_SETUP;
            PULSE:     tlim = LIM_PULSE;
            HOLD:      tlim = LIM_HOLD;
            EXEC_WAIT: tlim = long_wait ? LIM_CLEAR : LIM_EXEC;
            default:   tlim = '0;
        endcase
    end

    assign timer_done = (timer == tlim);

    // Round-robin only matters when both request; rr_ptr names the winner.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state == IDLE && init_done) begin
            if (req0 && req1) begin
                grant0 = !rr_ptr;
                grant1 = rr_ptr;
            end else begin
                grant0 = req0;
                grant1 = req1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            PWR_WAIT:  if (timer_done) state_nxt = LOAD;
            LOAD:      state_nxt = SETUP;
            SETUP:     if (timer_done) state_nxt = PULSE;
            PULSE:     if (timer_done) state_nxt = HOLD;
            HOLD:      if (timer_done) state_nxt = EXEC_WAIT;
            EXEC_WAIT: if (timer_done) state_nxt = (init_done || idx == 2'd3) ? IDLE : LOAD;
            IDLE:      if (grant0 || grant1) state_nxt = SETUP;
            default:   state_nxt = PWR_WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= PWR_WAIT;
            timer     <= '0;
            idx       <= 2'd0;
            rr_ptr    <= 1'b0;
            lcd_e     <= 1'b0;
            lcd_rs    <= 1'b0;
            lcd_data  <= 8'h00;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            init_done <= 1'b0;
            busy      <= 1'b1;
        end else begin
            state <= state_nxt;
            // Reload on every state change; IDLE is untimed so hold at zero.
            if (state_nxt != state || state == IDLE)
                timer <= '0;
            else
                timer <= timer + 1'b1;

            if (state == LOAD) begin
                lcd_rs   <= 1'b0;
                lcd_data <= init_byte(idx);
            end

            if (grant0) begin
                lcd_rs   <= rs0;
                lcd_data <= data0;
                rr_ptr   <= 1'b1;
            end else if (grant1) begin
                lcd_rs   <= rs1;
                lcd_data <= data1;
                rr_ptr   <= 1'b0;
            end

            ack0 <= grant0;
            ack1 <= grant1;

            if (state == EXEC_WAIT && timer_done && !init_done) begin
                if (idx == 2'd3)
                    init_done <= 1'b1;
                else
                    idx <= idx + 2'd1;
            end

            // Registered from the next state so E and busy line up with it.
            lcd_e <= (state_nxt == PULSE);
            busy  <= (state_nxt != IDLE);
        end
    end

    assign lcd_rw = 1'b0;

endmodule

// File: tb/tb_lcd_write_arbiter.sv
module tb_lcd_write_arbiter;

    localparam int T_POWERON = 50;
    localparam int T_SETUP   = 2;
    localparam int T_PULSE   = 4;
    localparam int T_HOLD    = 2;
    localparam int T_EXEC    = 10;
    localparam int T_CLEAR   = 40;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req0 = 1'b0, rs0 = 1'b0, req1 = 1'b0, rs1 = 1'b0;
    logic [7:0] data0 = 8'h00, data1 = 8'h00;
    logic       ack0, ack1, init_done, busy, lcd_e, lcd_rs, lcd_rw;
    logic [7:0] lcd_data;

    lcd_write_arbiter #(
        .T_POWERON(T_POWERON), .T_SETUP(T_SETUP), .T_PULSE(T_PULSE),
        .T_HOLD(T_HOLD), .T_EXEC(T_EXEC), .T_CLEAR(T_CLEAR), .CNT_W(20)
    ) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .rs0(rs0), .data0(data0), .ack0(ack0),
        .req1(req1), .rs1(rs1), .data1(data1), .ack1(ack1),
        .init_done(init_done), .busy(busy),
        .lcd_data(lcd_data), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_pass = 0;
    int n_tot  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    // Scoreboard of expected {rs, byte} per E strobe, in bus order.
    logic [8:0] sb_q[$];
    logic       e_prev = 1'b0;
    logic [8:0] bus_prev = '0;
    int         stable_viol = 0, overlap = 0, early_ack = 0;

    always @(negedge clk) begin
        if (lcd_e === 1'b1 && e_prev === 1'b0) begin
            check("sb_pulse_expected", (sb_q.size() > 0), 1);
            if (sb_q.size() > 0) check("sb_bus_byte", {lcd_rs, lcd_data}, sb_q.pop_front());
        end
        if (lcd_e === 1'b1 && e_prev === 1'b1 && {lcd_rs, lcd_data} !== bus_prev)
            stable_viol <= stable_viol + 1;
        if (ack0 === 1'b1 && ack1 === 1'b1) overlap <= overlap + 1;
        if ((ack0 === 1'b1 || ack1 === 1'b1) && init_done !== 1'b1) early_ack <= early_ack + 1;
        e_prev   <= lcd_e;
        bus_prev <= {lcd_rs, lcd_data};
    end

    logic [7:0] init_b[4] = '{8'h38, 8'h0D, 8'h01, 8'h80};
    logic       rr_m = 1'b0;   // model of the round-robin pointer

    task automatic wait_any_ack(output int who);
        int n = 0;
        while (!(ack0 || ack1) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("ack_arrives", int'(ack0 | ack1), 1);
        who = ack0 ? 0 : (ack1 ? 1 : -1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("returns_idle", int'(busy), 0);
    endtask

    // Release reset and check the full init sequence timing.
    task automatic release_and_check_init();
        int rel, n;
        int rise[4];
        int fall[4];
        foreach (init_b[k]) sb_q.push_back({1'b0, init_b[k]});
        reset = 1'b1;
        rel = cyc;
        for (int k = 0; k < 4; k++) begin
            n = 0;
            while (!lcd_e && n < 500) begin @(negedge clk); n++; end
            rise[k] = cyc;
            n = 0;
            while (lcd_e && n < 50) begin @(negedge clk); n++; end
            fall[k] = cyc;
            check("init_pulse_width", fall[k] - rise[k], T_PULSE);
            if (k == 0) check("poweron_to_e", rise[k] - rel, T_POWERON + 1 + T_SETUP);
            else check("init_gap", rise[k] - fall[k-1],
                       T_HOLD + ((k == 3) ? T_CLEAR : T_EXEC) + 1 + T_SETUP);
        end
        n = 0;
        while (!init_done && n < 100) begin @(negedge clk); n++; end
        check("init_done_time", cyc - fall[3], T_HOLD + T_EXEC);
        check("busy_after_init", int'(busy), 0);
        check("bus_after_init", {lcd_rs, lcd_data}, 9'h080);
    endtask

    typedef struct {
        logic       sel;
        logic       rs;
        logic [7:0] dat;
        int         busy_cyc;
    } vec_t;

    vec_t vt[8];
    int   who, n, e_first, e_last;
    logic exp_w[4];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{1'b0, 1'b1, 8'h49, 18};
        vt[1] = '{1'b1, 1'b0, 8'h01, 48};
        vt[2] = '{1'b0, 1'b0, 8'h0D, 18};
        vt[3] = '{1'b1, 1'b0, 8'h02, 48};
        vt[4] = '{1'b0, 1'b0, 8'h03, 48};
        vt[5] = '{1'b1, 1'b0, 8'h04, 18};
        vt[6] = '{1'b0, 1'b1, 8'h01, 18};
        vt[7] = '{1'b1, 1'b0, 8'h00, 18};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_lcd_e", int'(lcd_e), 0);
        check("rst_lcd_rs", int'(lcd_rs), 0);
        check("rst_lcd_data", int'(lcd_data), 0);
        check("rst_lcd_rw", int'(lcd_rw), 0);
        check("rst_acks", int'({ack0, ack1}), 0);
        check("rst_init_done", int'(init_done), 0);
        check("rst_busy", int'(busy), 1);
        rr_m = 1'b0;
        release_and_check_init();

        // Single writes from a vector table, alternating requesters
        foreach (vt[i]) begin
            if (vt[i].sel == 1'b0) begin rs0 = vt[i].rs; data0 = vt[i].dat; req0 = 1'b1; end
            else begin rs1 = vt[i].rs; data1 = vt[i].dat; req1 = 1'b1; end
            sb_q.push_back({vt[i].rs, vt[i].dat});
            wait_any_ack(who);
            check("tbl_ack_who", who, int'(vt[i].sel));
            rr_m = !vt[i].sel;
            req0 = 1'b0;
            req1 = 1'b0;
            n = 0; e_first = -1; e_last = -1;
            while (busy && n < 200) begin
                n++;
                @(negedge clk);
                if (n == 1) check("tbl_ack_width", int'(ack0 | ack1), 0);
                if (lcd_e) begin
                    if (e_first < 0) e_first = n + 1;
                    e_last = n + 1;
                end
            end
            check("tbl_busy_cycles", n, vt[i].busy_cyc);
            check("tbl_e_first", e_first, T_SETUP + 1);
            check("tbl_e_last", e_last, T_SETUP + T_PULSE);
            check("tbl_bus_held", {lcd_rs, lcd_data}, {vt[i].rs, vt[i].dat});
        end

        // Reset in the middle of an E pulse, with an early request pending
        rs0 = 1'b1; data0 = 8'h55; req0 = 1'b1;
        sb_q.push_back({1'b1, 8'h55});
        wait_any_ack(who);
        check("mid_ack_who", who, 0);
        req0 = 1'b0;
        n = 0;
        while (!lcd_e && n < 20) begin @(negedge clk); n++; end
        check("mid_e_high", int'(lcd_e), 1);
        reset = 1'b0;
        rs1 = 1'b1; data1 = 8'h2A; req1 = 1'b1;
        @(negedge clk);
        check("mid_rst_e", int'(lcd_e), 0);
        check("mid_rst_busy", int'(busy), 1);
        check("mid_rst_init_done", int'(init_done), 0);
        rr_m = 1'b0;
        @(negedge clk);
        release_and_check_init();
        sb_q.push_back({1'b1, 8'h2A});
        wait_any_ack(who);
        check("early_req_ack_who", who, 1);
        rr_m = 1'b0;
        req1 = 1'b0;
        wait_idle();

        // Contention: both requesters held for four transfers
        rs0 = 1'b1; data0 = 8'h41; rs1 = 1'b1; data1 = 8'h42;
        for (int k = 0; k < 4; k++) begin
            exp_w[k] = rr_m;
            sb_q.push_back(rr_m ? {1'b1, 8'h42} : {1'b1, 8'h41});
            rr_m = !rr_m;
        end
        req0 = 1'b1; req1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_any_ack(who);
            check("cont_ack_who", who, int'(exp_w[k]));
            if (k == 3) begin req0 = 1'b0; req1 = 1'b0; end
            @(negedge clk);
        end
        wait_idle();
        repeat (5) @(negedge clk);

        check("sb_drained", sb_q.size(), 0);
        check("ack_overlap", overlap, 0);
        check("bus_stable_while_e", stable_viol, 0);
        check("ack_before_init", early_ack, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
